// File: rtl/tape_mem_pkg.sv
// Shared types for the tape_mem block.
// The CLEAR state exists only when TAPE_MEM_CLEAR_EN is defined.
package tape_mem_pkg;

    typedef enum logic [1:0] {
        READ  = 2'd0,
        WRITE = 2'd1,
        INC   = 2'd2,
        DEC   = 2'd3
    } mem_op_t;

    typedef enum logic [1:0] {
`ifdef TAPE_MEM_CLEAR_EN
        CLEAR,
`endif
        IDLE,
        RMW
    } tape_state_t;

    typedef logic [7:0] BYTE;

endpackage

// File: rtl/tape_mem_if.sv
// Request/response bundle between a requester and tape_mem.
// Master drives requests, slave answers.
interface tape_mem_if #(
    parameter int DW = 8,
    parameter int AW = 8
);
    import tape_mem_pkg::*;

    logic          req_valid;
    logic          req_ready;
    mem_op_t       req_op;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          busy;

    modport master (
        output req_valid, req_op, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, busy
    );

endinterface

// File: rtl/tape_mem_ram.sv
// tape_ram: one write port, one registered read port.
// Contents are never reset; rdata holds while re is low.
module tape_ram #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // write port
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // registered read port, output held when not enabled
    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/tape_mem.sv
// tape_mem: word memory with READ/WRITE/INC/DEC requests.
// Optional power-up zero sweep enabled by TAPE_MEM_CLEAR_EN.
module tape_mem
    import tape_mem_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    tape_mem_if.slave  bus
);

    tape_state_t   state;
    tape_state_t   state_nx;
    logic          live;
    logic          accept;
    logic          dec_q;
    logic          rsp_valid_q;
    logic          use_ram;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] out_q;
    logic [DW-1:0] new_val;
    logic [DW-1:0] ram_rdata;
    logic          we;
    logic          re;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
`ifdef TAPE_MEM_CLEAR_EN
    logic [AW-1:0] cnt;
`endif

    assign bus.req_ready = live && (state == IDLE);
    assign accept        = bus.req_valid && bus.req_ready;
    assign bus.busy      = (state != IDLE);
    assign bus.rsp_valid = rsp_valid_q;

    // READ data comes straight from the RAM port, all else from out_q
    assign bus.rsp_rdata = use_ram ? ram_rdata : out_q;

    // the RAM port holds the word captured at INC/DEC acceptance
    assign new_val = dec_q ? ram_rdata - DW'(1)
                           : ram_rdata + DW'(1);

    tape_ram #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .re    (re),
        .raddr (bus.req_addr),
        .rdata (ram_rdata)
    );

    // next state and RAM port control
    always_comb begin
        state_nx = state;
        we       = 1'b0;
        re       = 1'b0;
        waddr    = addr_q;
        wdata    = '0;
        unique case (state)
`ifdef TAPE_MEM_CLEAR_EN
            CLEAR: begin
                we    = 1'b1;
                waddr = cnt;
                if (cnt == '1) state_nx = IDLE;
            end
`endif
            IDLE: begin
                if (accept) begin
                    unique case (bus.req_op)
                        READ: re = 1'b1;
                        WRITE: begin
                            we    = 1'b1;
                            waddr = bus.req_addr;
                            wdata = bus.req_wdata;
                        end
                        default: begin
                            re       = 1'b1;
                            state_nx = RMW;
                        end
                    endcase
                end
            end
            RMW: begin
                we       = 1'b1;
                wdata    = new_val;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // state, request capture and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
`ifdef TAPE_MEM_CLEAR_EN
            state <= CLEAR;
`else
            state <= IDLE;
`endif
            live        <= 1'b0;
            rsp_valid_q <= 1'b0;
            use_ram     <= 1'b0;
            out_q       <= '0;
            addr_q      <= '0;
            dec_q       <= 1'b0;
        end else begin
            state       <= state_nx;
            live        <= 1'b1;
            rsp_valid_q <= 1'b0;
            if (accept) begin
                addr_q <= bus.req_addr;
                dec_q  <= (bus.req_op == DEC);
                unique case (bus.req_op)
                    READ: begin
                        rsp_valid_q <= 1'b1;
                        use_ram     <= 1'b1;
                    end
                    WRITE: begin
                        rsp_valid_q <= 1'b1;
                        use_ram     <= 1'b0;
                        out_q       <= '0;
                    end
                    default: begin
                        // freeze the visible data before the RAM port moves
                        if (use_ram) out_q <= ram_rdata;
                        use_ram <= 1'b0;
                    end
                endcase
            end
            if (state == RMW) begin
                rsp_valid_q <= 1'b1;
                out_q       <= new_val;
            end
        end
    end

`ifdef TAPE_MEM_CLEAR_EN
    // sweep address counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (state == CLEAR) cnt <= cnt + AW'(1);
    end
`endif

endmodule

// File: tb/tb_tape_mem.sv
// Bench for tape_mem: vector table, reset abort, random vs model.
// Works with and without TAPE_MEM_CLEAR_EN.
module tb_tape_mem;
    import tape_mem_pkg::*;

    localparam int DW = 8;
    localparam int AW = 8;
`ifdef TAPE_MEM_CLEAR_EN
    localparam int CLR = 1;
    localparam int RDY_LAT = 256;
`else
    localparam int CLR = 0;
    localparam int RDY_LAT = 1;
`endif

    typedef struct {
        bit      v;
        mem_op_t op;
        BYTE     a;
        BYTE     wd;
        bit      rdy;
        bit      rv;
        BYTE     rd;
        bit      busy;
    } vec_t;

    typedef struct {
        int due;
        int val;
    } pend_t;

    logic clk = 1'b0;
    logic rst_n;
    int total = 0;
    int bad = 0;

    vec_t  tbl[$];
    pend_t pend[$];
    int    mm[256];
    int    stall;
    int    edge_n;
    int    last_rd;

    always #5 clk = ~clk;

    tape_mem_if #(.DW(DW), .AW(AW)) bus();

    tape_mem #(
        .DW (DW),
        .AW (AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic apply(bit v, mem_op_t op, BYTE a, BYTE wd);
        bus.req_valid = v;
        bus.req_op    = op;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(output int lat);
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_ready", int'(bus.req_ready), 0);
        chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
        chk("rst_rdata", int'(bus.rsp_rdata), 0);
        chk("rst_busy", int'(bus.busy), CLR);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("rst_hold_rsp_valid", int'(bus.rsp_valid), 0);
        end
        rst_n = 1'b1;
        lat = 0;
        while (!bus.req_ready && lat < 1000) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // model step: expectations from operation rules and timing only
    task automatic step(bit v, mem_op_t op, BYTE a, BYTE wd);
        bit rdy_e;
        bit rv_e;
        int nv;
        rdy_e = (stall == 0);
        chk("rnd_ready", int'(bus.req_ready), int'(rdy_e));
        apply(v, op, a, wd);
        edge_n++;
        if (!rdy_e) stall = 0;
        if (v && rdy_e) begin
            case (op)
                READ: pend.push_back('{edge_n, mm[a]});
                WRITE: begin
                    mm[a] = int'(wd);
                    pend.push_back('{edge_n, 0});
                end
                default: begin
                    if (op == INC) nv = (mm[a] + 1) % 256;
                    else nv = (mm[a] + 255) % 256;
                    mm[a] = nv;
                    pend.push_back('{edge_n + 1, nv});
                    stall = 1;
                end
            endcase
        end
        rv_e = (pend.size() > 0) && (pend[0].due == edge_n);
        if (rv_e) last_rd = pend.pop_front().val;
        chk("rnd_rsp_valid", int'(bus.rsp_valid), int'(rv_e));
        chk("rnd_rdata", int'(bus.rsp_rdata), last_rd);
    endtask

    initial begin
        int lat;
        bus.req_valid = 1'b0;
        bus.req_op    = READ;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        tbl.push_back('{1, WRITE, 8'h10, 8'hA5, 1, 1, 8'h00, 0});
        tbl.push_back('{1, READ,  8'h10, 8'h00, 1, 1, 8'hA5, 0});
        tbl.push_back('{1, WRITE, 8'h20, 8'hFF, 1, 1, 8'h00, 0});
        tbl.push_back('{1, INC,   8'h20, 8'h00, 1, 0, 8'h00, 1});
        tbl.push_back('{0, READ,  8'h00, 8'h00, 0, 1, 8'h00, 0});
        tbl.push_back('{1, DEC,   8'h20, 8'h00, 1, 0, 8'h00, 1});
        tbl.push_back('{0, READ,  8'h00, 8'h00, 0, 1, 8'hFF, 0});
        tbl.push_back('{1, READ,  8'h20, 8'h00, 1, 1, 8'hFF, 0});
        tbl.push_back('{1, WRITE, 8'h30, 8'h11, 1, 1, 8'h00, 0});
        tbl.push_back('{1, INC,   8'h30, 8'h00, 1, 0, 8'h00, 1});
        tbl.push_back('{1, WRITE, 8'h30, 8'h55, 0, 1, 8'h12, 0});
        tbl.push_back('{1, WRITE, 8'h30, 8'h55, 1, 1, 8'h00, 0});
        tbl.push_back('{1, READ,  8'h30, 8'h00, 1, 1, 8'h55, 0});
        tbl.push_back('{0, READ,  8'h00, 8'h00, 1, 0, 8'h55, 0});
        tbl.push_back('{1, INC,   8'h10, 8'h00, 1, 0, 8'h55, 1});
        tbl.push_back('{1, READ,  8'h10, 8'h00, 0, 1, 8'hA6, 0});
        tbl.push_back('{1, READ,  8'h10, 8'h00, 1, 1, 8'hA6, 0});

        do_reset(lat);
        chk("ready_latency", lat, RDY_LAT);

        foreach (tbl[i]) begin
            chk($sformatf("vec%0d_ready", i), int'(bus.req_ready), int'(tbl[i].rdy));
            apply(tbl[i].v, tbl[i].op, tbl[i].a, tbl[i].wd);
            chk($sformatf("vec%0d_rsp_valid", i), int'(bus.rsp_valid), int'(tbl[i].rv));
            chk($sformatf("vec%0d_rdata", i), int'(bus.rsp_rdata), int'(tbl[i].rd));
            chk($sformatf("vec%0d_busy", i), int'(bus.busy), int'(tbl[i].busy));
        end

        // reset in the middle of an INC must drop the write-back
        apply(1'b1, WRITE, 8'h40, 8'h07);
        apply(1'b1, INC, 8'h40, 8'h00);
        chk("abort_in_rmw_busy", int'(bus.busy), 1);
        do_reset(lat);
        chk("abort_ready_latency", lat, RDY_LAT);
        apply(1'b1, READ, 8'h40, 8'h00);
        chk("abort_read_valid", int'(bus.rsp_valid), 1);
        chk("abort_read_data", int'(bus.rsp_rdata), (CLR != 0) ? 0 : 7);

        // randomized traffic against the model
        do_reset(lat);
        chk("rnd_ready_latency", lat, RDY_LAT);
        pend.delete();
        stall = 0;
        edge_n = 0;
        last_rd = 0;
        for (int a = 0; a < 16; a++) begin
            step(1'b1, WRITE, BYTE'(a), BYTE'($urandom));
        end
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(3) != 0,
                 mem_op_t'($urandom_range(3)),
                 BYTE'($urandom_range(15)),
                 BYTE'($urandom));
        end
        for (int n = 0; n < 3; n++) begin
            step(1'b0, READ, 8'h00, 8'h00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
